// File: rtl/fp_accum_ctrl.sv
// Sequential FP32 accumulator controller: drives an external combinational adder.
// It also handles zero operands, exact cancellation and an optional ReLU on the final sum.
`timescale 1ns/1ps
module fp_accum_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             relu_en,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_data,
   output logic [XLEN-1:0]  add_a,
   output logic [XLEN-1:0]  add_b,
   input  logic [XLEN-1:0]  add_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_data
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state_reg, state_next;
   logic [XLEN-1:0]  acc_reg, acc_next;
   logic             acc_zero_reg, acc_zero_next;
   logic [CNT_W-1:0] remaining_reg, remaining_next;
   logic             relu_reg, relu_next;
   logic [XLEN-1:0]  out_data_reg, out_data_next;

   logic in_zero, res_zero, cancel;

   // Denormals are treated as zero: only the exponent field is tested.
   assign in_zero  = (in_data[30:23] == 8'd0);
   assign res_zero = (add_res[30:23] == 8'd0);
   assign cancel   = (in_data[30:0] == acc_reg[30:0]) && (in_data[31] != acc_reg[31]);

   assign add_a    = acc_reg;
   assign add_b    = in_data;
   assign out_data = out_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         acc_zero_reg  <= 1'b1;
         remaining_reg <= '0;
         relu_reg      <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         acc_zero_reg  <= acc_zero_next;
         remaining_reg <= remaining_next;
         relu_reg      <= relu_next;
         out_data_reg  <= out_data_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      acc_zero_next  = acc_zero_reg;
      remaining_next = remaining_reg;
      relu_next      = relu_reg;
      out_data_next  = out_data_reg;
      busy           = (state_reg != IDLE);
      in_ready       = (state_reg == ACCUM);
      out_valid      = (state_reg == DONE);

      case (state_reg)
         IDLE: begin
            if (start) begin
               relu_next     = relu_en;
               acc_next      = '0;
               acc_zero_next = 1'b1;
               if (count == '0) begin
                  out_data_next = '0;
                  state_next    = DONE;
               end else begin
                  remaining_next = count;
                  state_next     = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (in_valid) begin
               if (in_zero) begin
                  acc_next = acc_reg;
               end else if (acc_zero_reg) begin
                  acc_next      = in_data;
                  acc_zero_next = 1'b0;
               end else if (cancel) begin
                  // The adder cannot settle on an exact cancel, so its result is bypassed.
                  acc_next      = '0;
                  acc_zero_next = 1'b1;
               end else begin
                  acc_next      = add_res;
                  acc_zero_next = res_zero;
               end
               remaining_next = remaining_reg - 1'b1;
               if (remaining_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  state_next    = DONE;
                  out_data_next = (acc_zero_next || (relu_reg && acc_next[XLEN-1]))
                                  ? '0 : acc_next;
               end
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Self-checking bench for fp_accum_ctrl: directed runs plus randomized runs.
// Results are checked against an exact real-arithmetic model of the running sum.
`timescale 1ns/1ps
module tb_fp_accum_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  count;
   logic        relu_en;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic [31:0] add_res;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   int tests = 0;
   int fails = 0;
   logic [31:0] elems[$];

   fp_accum_ctrl #(.XLEN(32), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .count(count), .relu_en(relu_en),
      .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .add_a(add_a), .add_b(add_b), .add_res(add_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   // Exact widening of FP32 to double; zero/denormal maps to 0.0.
   function automatic real f2r(input logic [31:0] f);
      logic [10:0] e;
      if (f[30:23] == 8'd0) return 0.0;
      e = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   // Narrowing is exact for the values used here (small multiples of 0.5).
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   assign add_res = r2f(f2r(add_a) + f2r(add_b));

   function automatic logic [31:0] model_result(input bit relu);
      real s = 0.0;
      foreach (elems[i]) s += f2r(elems[i]);
      if (s == 0.0) return 32'h0;
      if (relu && s < 0.0) return 32'h0;
      return r2f(s);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in the drive window (just after a posedge) with the DUT idle.
   task automatic run(input bit relu, input bit gaps, input int stall,
                      input bit use_lit, input logic [31:0] lit);
      logic [31:0] exp;
      int n;
      n   = elems.size();
      exp = model_result(relu);
      if (use_lit) check("model_vs_literal", exp, lit);
      start = 1'b1; count = 8'(n); relu_en = relu;
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            in_valid = 1'b0; start = 1'b1; count = 8'($urandom_range(0, 5));
            @(negedge clk);
            check("gap_in_ready", {31'd0, in_ready}, 32'd1);
            check("gap_out_valid", {31'd0, out_valid}, 32'd0);
            step();
            start = 1'b0;
         end
         in_valid = 1'b1; in_data = elems[i];
         @(negedge clk);
         check("accum_in_ready", {31'd0, in_ready}, 32'd1);
         check("accum_busy", {31'd0, busy}, 32'd1);
         check("accum_out_valid", {31'd0, out_valid}, 32'd0);
         step();
         in_valid = 1'b0;
      end
      @(negedge clk);
      check("done_out_valid", {31'd0, out_valid}, 32'd1);
      check("done_in_ready", {31'd0, in_ready}, 32'd0);
      check("done_out_data", out_data, exp);
      if (use_lit) check("done_out_data_literal", out_data, lit);
      $display("[TB] run n=%0d relu=%0d gaps=%0d stall=%0d -> out_data=%08h expected=%08h",
               n, relu, gaps, stall, out_data, exp);
      for (int s = 0; s < stall; s++) begin
         step();
         start = 1'b1; count = 8'd3;
         @(negedge clk);
         check("stall_out_valid", {31'd0, out_valid}, 32'd1);
         check("stall_out_data", out_data, exp);
      end
      step();
      out_ready = 1'b1; start = 1'b1; count = 8'd2;
      step();
      out_ready = 1'b0; start = 1'b0;
      @(negedge clk);
      check("after_ack_out_valid", {31'd0, out_valid}, 32'd0);
      check("after_ack_busy", {31'd0, busy}, 32'd0);
      check("after_ack_out_data_held", out_data, exp);
      step();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; count = '0; relu_en = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd0);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_data", out_data, 32'h0);
      check("reset_add_a", add_a, 32'h0);
      @(negedge clk); rst = 1'b0;
      step();

      // T1
      elems = '{32'h3F800000, 32'h40000000, 32'h3F000000};
      run(1'b0, 1'b0, 0, 1'b1, 32'h40600000);
      // T2
      elems = '{32'h3FC00000, 32'h00000000, 32'hBFC00000, 32'h40000000};
      run(1'b0, 1'b0, 0, 1'b1, 32'h40000000);
      // T3
      elems = '{32'h3F800000, 32'hC0400000};
      run(1'b1, 1'b0, 0, 1'b1, 32'h00000000);
      run(1'b0, 1'b0, 2, 1'b1, 32'hC0000000);
      // T4
      elems = {};
      run(1'b0, 1'b0, 0, 1'b1, 32'h00000000);
      // T5
      elems = '{32'h3F800000, 32'h40000000, 32'h3F000000};
      run(1'b0, 1'b1, 5, 1'b1, 32'h40600000);
      run(1'b0, 1'b0, 0, 1'b1, 32'h40600000);

      // T6: abort after one accept, with a nonzero out_data left from the last run
      elems = '{32'hC0400000};
      run(1'b0, 1'b0, 0, 1'b1, 32'hC0400000);
      start = 1'b1; count = 8'd4; relu_en = 1'b0;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 32'h3F800000;
      step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd0);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_out_data", out_data, 32'h0);
      check("abort_add_a", add_a, 32'h0);
      $display("[TB] abort: busy=%0d out_valid=%0d out_data=%08h", busy, out_valid, out_data);
      @(negedge clk); rst = 1'b0;
      step();
      elems = '{32'h3F800000, 32'h40000000, 32'h3F000000};
      run(1'b0, 1'b0, 0, 1'b1, 32'h40600000);

      // Randomized runs, including forced exact cancellations and denormals
      for (int r = 0; r < 25; r++) begin
         real p;
         int n;
         logic [31:0] e;
         p = 0.0;
         n = $urandom_range(0, 8);
         elems = {};
         for (int i = 0; i < n; i++) begin
            int c, k;
            c = $urandom_range(0, 9);
            if (c == 0) e = 32'h0;
            else if (c == 1) e = 32'h00000123;
            else if (c == 2 && p != 0.0) e = r2f(-p);
            else begin
               k = $urandom_range(1, 64);
               e = r2f(($urandom_range(0, 1) == 1) ? -(k * 0.5) : (k * 0.5));
            end
            p += f2r(e);
            elems.push_back(e);
         end
         run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'b0, 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
